// File: rtl/uart_pkg.sv
// Shared UART types, constants and helpers used by the TX engine (and later the RX side).
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam int OVERSAMPLE = 16;

  // Word length select encoding
  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  // Keep only the low 5..8 bits selected by wls
  function automatic logic [7:0] uart_mask(input logic [7:0] data, input logic [1:0] wls);
    logic [7:0] m;
    m = 8'hFF >> (WLS_8 - wls);
    return data & m;
  endfunction

  // Parity bit over the masked data; stick parity forces ~eps
  function automatic logic uart_parity(input logic [7:0] data, input logic [1:0] wls,
                                       input logic eps, input logic sp);
    logic [7:0] m;
    m = uart_mask(data, wls);
    if (sp) return ~eps;
    return eps ? ^m : ~^m;
  endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// TX FIFO read port: the engine is the master (it pops), the FIFO is the slave.
interface uart_tx_engine_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_rd;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rd_data;

  modport master (output fifo_rd, input fifo_empty, input fifo_rd_data);
  modport slave  (input fifo_rd, output fifo_empty, output fifo_rd_data);
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit engine: pops words from the TX FIFO and serializes them as
// start / 5-8 data bits LSB-first / optional parity / 1, 1.5 or 2 stop bits,
// timed by an external oversampling baud_tick enable.
module uart_tx_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             baud_tick,
  uart_tx_engine_if.master fifo,
  input  logic [1:0]       wls,
  input  logic             stb,
  input  logic             pen,
  input  logic             eps,
  input  logic             sp,
  input  logic             brk,
  output logic             txd,
  output logic             tx_busy,
  output logic             tx_empty
);
  import uart_pkg::*;

  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] TICK_HALF = 4'(OVERSAMPLE / 2 - 1);

  tx_state_e state_q, state_d;
  logic [3:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shreg_q, shreg_d;
  logic [1:0] wls_q, wls_d;
  logic       stb_q, stb_d;
  logic       pen_q, pen_d;
  logic       par_q, par_d;
  logic       txd_q, txd_d;

  logic [DATA_WIDTH-1:0] head_word;
  logic       load;
  logic       line;
  logic       bit_end;
  logic       stop_end;
  logic [2:0] last_bit;

  assign head_word = fifo.fifo_rd_data;
  assign bit_end   = baud_tick && (tick_q == TICK_LAST);
  assign last_bit  = 3'd4 + {1'b0, wls_q};
  // 1 stop: one bit period; 2 stop: two; 1.5 stop (5-bit words): ends half-way through the second
  assign stop_end  = baud_tick &&
                     (stb_q ? (bit_q == 3'd1 &&
                               tick_q == ((wls_q == WLS_5) ? TICK_HALF : TICK_LAST))
                            : (tick_q == TICK_LAST));

  // Next-state, datapath and line level; txd is computed from the post-edge state so it lines up with it
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    wls_d   = wls_q;
    stb_d   = stb_q;
    pen_d   = pen_q;
    par_d   = par_q;
    load    = 1'b0;
    line    = 1'b1;
    if (baud_tick) tick_d = tick_q + 4'd1;
    case (state_q)
      ST_IDLE:   load = !fifo.fifo_empty;
      ST_START:  if (bit_end) state_d = ST_DATA;
      ST_DATA: begin
        if (bit_end) begin
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_q == last_bit) begin
            bit_d   = '0;
            state_d = pen_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      ST_PARITY: if (bit_end) state_d = ST_STOP;
      ST_STOP: begin
        if (stop_end) begin
          // Chain straight into the next frame when more data is waiting
          if (!fifo.fifo_empty) load = 1'b1;
          else                  state_d = ST_IDLE;
        end else if (bit_end) begin
          bit_d = bit_q + 3'd1;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
    if (load) begin
      shreg_d = uart_mask(head_word[7:0], wls);
      wls_d   = wls;
      stb_d   = stb;
      pen_d   = pen;
      par_d   = uart_parity(head_word[7:0], wls, eps, sp);
      tick_d  = '0;
      bit_d   = '0;
      state_d = ST_START;
    end
    case (state_d)
      ST_START:  line = 1'b0;
      ST_DATA:   line = shreg_d[0];
      ST_PARITY: line = par_d;
      default:   line = 1'b1;
    endcase
    txd_d = brk ? 1'b0 : line;
  end

  // FSM and datapath registers; a popped word is simply dropped on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      wls_q   <= '0;
      stb_q   <= 1'b0;
      pen_q   <= 1'b0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      wls_q   <= wls_d;
      stb_q   <= stb_d;
      pen_q   <= pen_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
    end
  end

  assign fifo.fifo_rd = load && !rst;
  assign txd          = txd_q;
  assign tx_busy      = (state_q != ST_IDLE);
  assign tx_empty     = (state_q == ST_IDLE) && fifo.fifo_empty;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: a tick-level frame model predicts fifo_rd, txd,
// tx_busy and tx_empty every cycle; directed frames add literal spot checks.
module tb_uart_tx_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick = 1'b1;
  logic [1:0] wls = 2'b11;
  logic       stb = 1'b0, pen = 1'b0, eps = 1'b0, sp = 1'b0, brk = 1'b0;
  logic       txd, tx_busy, tx_empty;

  int checks = 0;
  int errors = 0;

  logic [7:0] fq[$];
  logic       pop_pend = 1'b0;
  int         tmode = 0;
  int         tcnt = 0;

  uart_tx_engine_if #(.DATA_WIDTH(8)) ifc();

  uart_tx_engine #(.DATA_WIDTH(8), .OVERSAMPLE(16)) dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .fifo(ifc),
    .wls(wls), .stb(stb), .pen(pen), .eps(eps), .sp(sp), .brk(brk),
    .txd(txd), .tx_busy(tx_busy), .tx_empty(tx_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- frame model (tick granularity) ----------------
  function automatic int frame_len(input logic [1:0] w, input logic s, input logic p);
    int stop;
    stop = !s ? 16 : ((w == 2'b00) ? 24 : 32);
    return (6 + int'(w) + int'(p)) * 16 + stop;
  endfunction

  function automatic logic frame_level(input logic [7:0] d, input logic [1:0] w, input logic p,
                                       input logic e, input logic s_p, input int idx);
    int wl, slot, ones;
    logic [7:0] md;
    logic par;
    wl   = 5 + int'(w);
    slot = idx / 16;
    md   = d & 8'((1 << wl) - 1);
    ones = $countones(md);
    par  = s_p ? !e : (e ? (ones % 2 == 1) : (ones % 2 == 0));
    if (slot == 0) return 1'b0;
    if (slot <= wl) return md[slot-1];
    if (p && slot == wl + 1) return par;
    return 1'b1;
  endfunction

  task automatic drive_fifo();
    ifc.fifo_empty   = (fq.size() == 0);
    ifc.fifo_rd_data = (fq.size() != 0) ? fq[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] d);
    fq.push_back(d);
    drive_fifo();
  endtask

  // FIFO pop and baud tick generation, just after each rising edge
  always @(posedge clk) begin
    #1;
    if (pop_pend) begin
      if (fq.size() != 0) void'(fq.pop_front());
      pop_pend = 1'b0;
    end
    drive_fifo();
    tcnt++;
    baud_tick = (tmode == 0) ? 1'b1 : (tcnt % 3 == 0);
  end

  logic       have_exp = 1'b0;
  logic       m_act = 1'b0;
  int         m_idx = 0, m_len = 0;
  logic [7:0] m_d;
  logic [1:0] m_w;
  logic       m_pen, m_eps, m_sp;
  logic       e_txd = 1'b1, e_busy = 1'b0, e_pop = 1'b0;

  // Compare process: outputs vs. last prediction, then advance the model by one cycle
  always @(negedge clk) begin
    if (have_exp) begin
      chk("txd", txd, e_txd);
      chk("tx_busy", tx_busy, e_busy);
      chk("tx_empty", tx_empty, !e_busy && fq.size() == 0);
    end
    if (rst) begin
      m_act = 1'b0; e_pop = 1'b0; e_txd = 1'b1; e_busy = 1'b0;
    end else begin
      if (baud_tick && m_act) begin
        m_idx++;
        if (m_idx == m_len) m_act = 1'b0;
      end
      e_pop = !m_act && fq.size() != 0;
      if (e_pop) begin
        m_act = 1'b1; m_idx = 0; m_d = fq[0]; m_w = wls;
        m_pen = pen; m_eps = eps; m_sp = sp;
        m_len = frame_len(wls, stb, pen);
      end
      e_txd  = brk ? 1'b0 : (m_act ? frame_level(m_d, m_w, m_pen, m_eps, m_sp, m_idx) : 1'b1);
      e_busy = m_act;
    end
    chk("fifo_rd", ifc.fifo_rd, e_pop);
    pop_pend = ifc.fifo_rd;
    have_exp = 1'b1;
  end

  // ---------------- stimulus ----------------
  task automatic cfg(input logic [1:0] w, input logic s, input logic p, input logic e, input logic k);
    wls = w; stb = s; pen = p; eps = e; sp = k;
  endtask

  task automatic start_cycle();
    @(posedge clk); #2;
  endtask

  task automatic nneg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((tx_busy !== 1'b0 || fq.size() != 0 || pop_pend) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("idle_timeout", 1, 0);
  endtask

  logic eps_t[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic sp_t[4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic par_t[4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    drive_fifo();
    // pin the model with hand-computed values
    chk("len_8n1", frame_len(2'b11, 1'b0, 1'b0), 160);
    chk("len_5n15", frame_len(2'b00, 1'b1, 1'b0), 120);
    chk("len_7o2", frame_len(2'b10, 1'b1, 1'b1), 176);
    chk("mdl_even", frame_level(8'hA3, 2'b11, 1'b1, 1'b1, 1'b0, 144), 0);
    chk("mdl_odd", frame_level(8'hA3, 2'b11, 1'b1, 1'b0, 1'b0, 144), 1);
    chk("mdl_stick1", frame_level(8'hA3, 2'b11, 1'b1, 1'b1, 1'b1, 144), 0);
    chk("mdl_stick0", frame_level(8'hA3, 2'b11, 1'b1, 1'b0, 1'b1, 144), 1);
    chk("mdl_mask", frame_level(8'hE0, 2'b00, 1'b1, 1'b1, 1'b0, 96), 0);
    chk("mdl_bit0", frame_level(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 16), 1);

    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_txd", txd, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_temt", tx_empty, 1);
    chk("rst_rd", ifc.fifo_rd, 0);

    // single 8N1 frame of 0x55
    cfg(2'b11, 0, 0, 0, 0);
    start_cycle(); push(8'h55);
    nneg(1);   chk("n1_rd", ifc.fifo_rd, 1);
    nneg(1);   chk("n1_start", txd, 0);
    nneg(16);  chk("n1_d0", txd, 1);
    nneg(16);  chk("n1_d1", txd, 0);
    nneg(127); chk("n1_busy160", tx_busy, 1); chk("n1_stop", txd, 1);
    nneg(1);   chk("n1_busy161", tx_busy, 0); chk("n1_temt", tx_empty, 1);
    wait_idle();

    // parity modes on 0xA3, parity slot spans cycles 145..160
    for (int k = 0; k < 4; k++) begin
      cfg(2'b11, 0, 1, eps_t[k], sp_t[k]);
      start_cycle(); push(8'hA3);
      nneg(151); chk("parity", txd, {31'd0, par_t[k]});
      wait_idle();
    end

    // 5-bit word, 1.5 stop bits
    cfg(2'b00, 1, 0, 0, 0);
    start_cycle(); push(8'hFF);
    nneg(101); chk("w5_stop", txd, 1);
    nneg(20);  chk("w5_busy120", tx_busy, 1);
    nneg(1);   chk("w5_busy121", tx_busy, 0);
    wait_idle();

    // parity ignores bits above the word length
    cfg(2'b00, 0, 1, 1, 0);
    start_cycle(); push(8'hE0);
    nneg(101); chk("w5_par_mask", txd, 0);
    wait_idle();

    // back-to-back frames
    cfg(2'b11, 0, 0, 0, 0);
    start_cycle(); push(8'h01); push(8'h02);
    nneg(1);   chk("b2b_rd0", ifc.fifo_rd, 1);
    nneg(1);   chk("b2b_rd1", ifc.fifo_rd, 0);
    nneg(159); chk("b2b_rd160", ifc.fifo_rd, 1); chk("b2b_txd160", txd, 1);
    nneg(1);   chk("b2b_txd161", txd, 0); chk("b2b_rd161", ifc.fifo_rd, 0);
    nneg(159); chk("b2b_busy320", tx_busy, 1);
    nneg(1);   chk("b2b_temt321", tx_empty, 1);
    wait_idle();

    // break during DATA
    start_cycle(); push(8'h5A);
    repeat (40) @(posedge clk);
    #2 brk = 1'b1;
    nneg(2);   chk("brk_on", txd, 0);
    @(posedge clk); #2 brk = 1'b0;
    nneg(1);   chk("brk_hold", txd, 0);
    nneg(1);   chk("brk_off", txd, 1);
    nneg(117); chk("brk_busy160", tx_busy, 1);
    nneg(1);   chk("brk_busy161", tx_busy, 0);
    wait_idle();

    // reset mid-DATA with another word still queued
    start_cycle(); push(8'h33); push(8'h44);
    repeat (50) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    nneg(1);
    chk("mrst_txd", txd, 1);
    chk("mrst_busy", tx_busy, 0);
    chk("mrst_temt", tx_empty, 0);
    chk("mrst_rd", ifc.fifo_rd, 1);
    wait_idle();

    // slow ticks, 7O2, config changed mid-frame must not matter
    tmode = 1;
    cfg(2'b10, 1, 1, 0, 0);
    start_cycle(); push(8'h6B);
    repeat (5) @(posedge clk);
    #2 cfg(2'b00, 0, 0, 1, 1);
    wait_idle();
    tmode = 0;

    // 6-bit, 2 stop, stick parity
    cfg(2'b01, 1, 1, 0, 1);
    start_cycle(); push(8'h2C);
    wait_idle();

    nneg(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
